// File: rtl/scpad_types_pkg.sv
// Shared sizes, state encoding and lane record for the scratchpad write crossbar.
package scpad_types_pkg;

   localparam int NUM_LANES = 32;
   localparam int NUM_BANKS = 32;
   localparam int BANK_W    = $clog2(NUM_BANKS);
   localparam int LANE_W    = $clog2(NUM_LANES);
   localparam int SLOT_W    = 10;
   localparam int DATA_W    = 16;
   localparam int ID_W      = 4;
   localparam int STAT_W    = 16;

   typedef enum logic [1:0] {
      X_IDLE,
      X_ISSUE,
      X_DONE
   } wxbar_state_t;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [SLOT_W-1:0] slot;
      logic [DATA_W-1:0] data;
   } wxbar_lane_t;

endpackage

// File: rtl/scpad_bank_pick.sv
// Per-bank priority encoder: picks the lowest-index pending lane aimed at each bank
// and reports which lanes those picks retire.
module scpad_bank_pick
   import scpad_types_pkg::*;
(
   input  logic [NUM_LANES-1:0]        pending,
   input  logic [NUM_LANES*BANK_W-1:0] bank,
   output logic [NUM_BANKS-1:0]        bank_vld,
   output logic [NUM_BANKS*LANE_W-1:0] bank_lane,
   output logic [NUM_LANES-1:0]        clr_mask
);

   logic [LANE_W-1:0] lane_of [NUM_BANKS];

   always_comb begin
      bank_vld = '0;
      bank_lane = '0;
      clr_mask = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         lane_of[b] = '0;
         // Scan downwards so the lowest matching lane is the last one written.
         for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (pending[l] && (bank[l*BANK_W +: BANK_W] == BANK_W'(b))) begin
               bank_vld[b] = 1'b1;
               lane_of[b] = LANE_W'(l);
            end
         end
         bank_lane[b*LANE_W +: LANE_W] = lane_of[b];
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         clr_mask[l] = pending[l] && (lane_of[bank[l*BANK_W +: BANK_W]] == LANE_W'(l));
      end
   end

endmodule

// File: rtl/scpad_wr_xbar.sv
// Write-path crossbar: routes one lane descriptor onto banked SRAM ports, serialising
// bank conflicts. Optional SCPAD_WXBAR_STATS_EN adds a saturating conflict-cycle counter.
module scpad_wr_xbar
   import scpad_types_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        desc_valid,
   output logic                        desc_ready,
   input  logic [ID_W-1:0]             desc_id,
   input  logic [NUM_LANES-1:0]        desc_mask,
   input  logic [NUM_LANES*BANK_W-1:0] desc_bank,
   input  logic [NUM_LANES*SLOT_W-1:0] desc_slot,
   input  logic [NUM_LANES*DATA_W-1:0] desc_data,
   input  logic                        sram_ready,
   output logic [NUM_BANKS-1:0]        sram_wen,
   output logic [NUM_BANKS*SLOT_W-1:0] sram_addr,
   output logic [NUM_BANKS*DATA_W-1:0] sram_wdata,
   output logic                        done_valid,
   output logic [ID_W-1:0]             done_id,
   input  logic                        done_ready
`ifdef SCPAD_WXBAR_STATS_EN
   ,
   output logic [STAT_W-1:0]           stat_conflict_cycles
`endif
);

   wxbar_state_t state;
   logic [NUM_LANES-1:0]        pending;
   logic [NUM_LANES-1:0]        pending_next;
   logic [NUM_LANES-1:0]        clr_mask;
   logic [ID_W-1:0]             id_q;
   wxbar_lane_t                 lanes_q [NUM_LANES];
   logic [NUM_LANES*BANK_W-1:0] bank_flat;
   logic [NUM_BANKS-1:0]        bank_vld;
   logic [NUM_BANKS*LANE_W-1:0] bank_lane;
   logic                        accept;
   logic                        issuing;

   assign accept  = (state == X_IDLE) && desc_valid;
   assign issuing = (state == X_ISSUE);

   // Descriptor payload is pure data and carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         id_q <= desc_id;
         for (int l = 0; l < NUM_LANES; l++) begin
            lanes_q[l] <= '{bank: desc_bank[l*BANK_W +: BANK_W],
                            slot: desc_slot[l*SLOT_W +: SLOT_W],
                            data: desc_data[l*DATA_W +: DATA_W]};
         end
      end
   end

   always_comb begin
      bank_flat = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         bank_flat[l*BANK_W +: BANK_W] = lanes_q[l].bank;
      end
   end

   scpad_bank_pick u_pick (
      .pending   (pending),
      .bank      (bank_flat),
      .bank_vld  (bank_vld),
      .bank_lane (bank_lane),
      .clr_mask  (clr_mask)
   );

   assign pending_next = sram_ready ? (pending & ~clr_mask) : pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= X_IDLE;
         pending    <= '0;
         desc_ready <= 1'b1;
         done_valid <= 1'b0;
         done_id    <= '0;
      end else begin
         case (state)
            X_IDLE: begin
               if (desc_valid) begin
                  pending    <= desc_mask;
                  desc_ready <= 1'b0;
                  state      <= X_ISSUE;
               end
            end
            X_ISSUE: begin
               // An empty mask still spends one cycle here before completing.
               pending <= pending_next;
               if (pending_next == '0) begin
                  done_valid <= 1'b1;
                  done_id    <= id_q;
                  state      <= X_DONE;
               end
            end
            X_DONE: begin
               if (done_ready) begin
                  done_valid <= 1'b0;
                  desc_ready <= 1'b1;
                  state      <= X_IDLE;
               end
            end
            default: begin
               state      <= X_IDLE;
               pending    <= '0;
               desc_ready <= 1'b1;
               done_valid <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      sram_wen   = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (issuing && bank_vld[b]) begin
            sram_wen[b] = 1'b1;
            sram_addr[b*SLOT_W +: SLOT_W]  = lanes_q[bank_lane[b*LANE_W +: LANE_W]].slot;
            sram_wdata[b*DATA_W +: DATA_W] = lanes_q[bank_lane[b*LANE_W +: LANE_W]].data;
         end
      end
   end

`ifdef SCPAD_WXBAR_STATS_EN
   logic first_q;

   // Counts productive issue cycles after the first one of each descriptor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_conflict_cycles <= '0;
         first_q              <= 1'b0;
      end else if (accept) begin
         first_q <= 1'b1;
      end else if (issuing && sram_ready) begin
         first_q <= 1'b0;
         if (!first_q && (stat_conflict_cycles != {STAT_W{1'b1}})) begin
            stat_conflict_cycles <= stat_conflict_cycles + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_scpad_wr_xbar.sv
// Bench for scpad_wr_xbar: directed scenarios plus random descriptors against a per-bank queue model.
module tb_scpad_wr_xbar;
   import scpad_types_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        desc_valid;
   logic                        desc_ready;
   logic [ID_W-1:0]             desc_id;
   logic [NUM_LANES-1:0]        desc_mask;
   logic [NUM_LANES*BANK_W-1:0] desc_bank;
   logic [NUM_LANES*SLOT_W-1:0] desc_slot;
   logic [NUM_LANES*DATA_W-1:0] desc_data;
   logic                        sram_ready;
   logic [NUM_BANKS-1:0]        sram_wen;
   logic [NUM_BANKS*SLOT_W-1:0] sram_addr;
   logic [NUM_BANKS*DATA_W-1:0] sram_wdata;
   logic                        done_valid;
   logic [ID_W-1:0]             done_id;
   logic                        done_ready;
`ifdef SCPAD_WXBAR_STATS_EN
   logic [STAT_W-1:0]           stat_conflict_cycles;
   int                          stat_before;
`endif

   int checks = 0;
   int failures = 0;

   logic [NUM_LANES-1:0] m;
   logic [BANK_W-1:0]    bk [NUM_LANES];
   logic [SLOT_W-1:0]    sl [NUM_LANES];
   logic [DATA_W-1:0]    dt [NUM_LANES];

   always #5 clk = ~clk;

   scpad_wr_xbar dut (
      .clk        (clk),
      .rst        (rst),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_id    (desc_id),
      .desc_mask  (desc_mask),
      .desc_bank  (desc_bank),
      .desc_slot  (desc_slot),
      .desc_data  (desc_data),
      .sram_ready (sram_ready),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .done_valid (done_valid),
      .done_id    (done_id),
      .done_ready (done_ready)
`ifdef SCPAD_WXBAR_STATS_EN
      ,
      .stat_conflict_cycles (stat_conflict_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, desc_ready, 1);
      chk({tag, "_wen"}, sram_wen, 0);
      chk({tag, "_addr"}, sram_addr, 0);
      chk({tag, "_wdata"}, sram_wdata, 0);
      chk({tag, "_done_valid"}, done_valid, 0);
      chk({tag, "_done_id"}, done_id, 0);
   endtask

   task automatic load_desc(input logic [ID_W-1:0] id);
      desc_valid = 1'b1;
      desc_id    = id;
      desc_mask  = m;
      for (int l = 0; l < NUM_LANES; l++) begin
         desc_bank[l*BANK_W +: BANK_W] = bk[l];
         desc_slot[l*SLOT_W +: SLOT_W] = sl[l];
         desc_data[l*DATA_W +: DATA_W] = dt[l];
      end
   endtask

   // Model: lanes aimed at a bank form an ascending queue; write step w issues element w of every queue.
   task automatic run_desc(input logic [ID_W-1:0] id, input int st_lo, input int st_hi, input int hold);
      int q [NUM_BANKS][$];
      int k = 0;
      int w = 0;
      int cyc = 0;
      int waits = 0;
      logic [NUM_BANKS-1:0]        ew;
      logic [NUM_BANKS*SLOT_W-1:0] ea;
      logic [NUM_BANKS*DATA_W-1:0] ed;
      for (int l = 0; l < NUM_LANES; l++) if (m[l]) q[bk[l]].push_back(l);
      for (int b = 0; b < NUM_BANKS; b++) if (q[b].size() > k) k = q[b].size();
      @(posedge clk); #1;
      while (!desc_ready && waits < 50) begin
         @(posedge clk); #1;
         waits++;
      end
      chk("accept_ready", desc_ready, 1);
      load_desc(id);
      @(posedge clk); #1;
      desc_valid = 1'b0;
      cyc = 1;
      do begin
         sram_ready = !(cyc >= st_lo && cyc <= st_hi);
         ew = '0; ea = '0; ed = '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w < q[b].size()) begin
               ew[b] = 1'b1;
               ea[b*SLOT_W +: SLOT_W] = sl[q[b][w]];
               ed[b*DATA_W +: DATA_W] = dt[q[b][w]];
            end
         end
         @(negedge clk);
         chk("issue_wen", sram_wen, ew);
         chk("issue_addr", sram_addr, ea);
         chk("issue_wdata", sram_wdata, ed);
         chk("issue_done_valid", done_valid, 0);
         chk("issue_desc_ready", desc_ready, 0);
         if (sram_ready) w++;
         @(posedge clk); #1;
         cyc++;
      end while (w < k && cyc < 200);
      sram_ready = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_done_valid", done_valid, 1);
         chk("hold_desc_ready", desc_ready, 0);
         @(posedge clk); #1;
      end
      done_ready = 1'b1;
      @(negedge clk);
      chk("done_valid", done_valid, 1);
      chk("done_id", done_id, id);
      chk("done_wen", sram_wen, 0);
      @(posedge clk); #1;
      done_ready = 1'b0;
      @(negedge clk);
      chk("after_done_valid", done_valid, 0);
      chk("after_desc_ready", desc_ready, 1);
   endtask

   task automatic all_conflict(input int bank);
      m = '1;
      for (int l = 0; l < NUM_LANES; l++) begin
         bk[l] = BANK_W'(bank);
         sl[l] = SLOT_W'(l);
         dt[l] = DATA_W'($urandom);
      end
   endtask

   initial begin
      rst = 1'b1;
      desc_valid = 1'b0;
      desc_id = '0;
      desc_mask = '0;
      desc_bank = '0;
      desc_slot = '0;
      desc_data = '0;
      sram_ready = 1'b1;
      done_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
`ifdef SCPAD_WXBAR_STATS_EN
      chk("reset_stat", stat_conflict_cycles, 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Identity map: one write cycle, all banks.
      m = '1;
      for (int l = 0; l < NUM_LANES; l++) begin
         bk[l] = BANK_W'(l);
         sl[l] = SLOT_W'(3);
         dt[l] = DATA_W'(16'h100 + l);
      end
      run_desc(4'h3, 0, -1, 0);

      // Every lane on bank 5: 32 serialised writes.
      all_conflict(5);
      run_desc(4'h5, 0, -1, 1);

      // Two lanes, same bank and slot: lane 3 then lane 7.
      m = '0;
      m[3] = 1'b1;
      m[7] = 1'b1;
      for (int l = 0; l < NUM_LANES; l++) begin
         bk[l] = BANK_W'($urandom);
         sl[l] = SLOT_W'($urandom);
         dt[l] = DATA_W'($urandom);
      end
      bk[3] = 2; bk[7] = 2;
      sl[3] = 9; sl[7] = 9;
      dt[3] = 16'hAAAA; dt[7] = 16'h5555;
      run_desc(4'h7, 0, -1, 0);

      // Stall for cycles 2..4 on an all-conflict descriptor.
      all_conflict(11);
`ifdef SCPAD_WXBAR_STATS_EN
      stat_before = int'(stat_conflict_cycles);
`endif
      run_desc(4'hA, 2, 4, 0);
`ifdef SCPAD_WXBAR_STATS_EN
      chk("stat_after_stall", stat_conflict_cycles, stat_before + 31);
`endif

      // Empty mask, consumer slow for 5 cycles.
      m = '0;
      run_desc(4'hC, 0, -1, 5);

      // Reset in cycle 4 of an all-conflict descriptor.
      all_conflict(20);
      @(posedge clk); #1;
      load_desc(4'h9);
      @(posedge clk); #1;
      desc_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid_reset");
`ifdef SCPAD_WXBAR_STATS_EN
      chk("mid_reset_stat", stat_conflict_cycles, 0);
`endif
      repeat (3) begin
         @(negedge clk);
         chk("post_reset_no_done", done_valid, 0);
      end
      all_conflict(1);
      m[0] = 1'b0;
      run_desc(4'h1, 0, -1, 0);

      // Random descriptors with varied conflict depth and stall windows.
      for (int t = 0; t < 25; t++) begin
         int r;
         int lo;
         r = $urandom_range(0, 31);
         m = ($urandom_range(0, 7) == 0) ? '0 : NUM_LANES'($urandom);
         for (int l = 0; l < NUM_LANES; l++) begin
            bk[l] = BANK_W'($urandom_range(0, r));
            sl[l] = SLOT_W'($urandom);
            dt[l] = DATA_W'($urandom);
         end
         lo = $urandom_range(1, 8);
         run_desc(ID_W'($urandom), lo, lo + $urandom_range(0, 3) - 1, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
